// File: rtl/id_exe_if.sv
// ID->EXE stage bundle: decode-side inputs (operands, instruction word,
// hazard controls) and execute-side registered outputs with event counters.
interface id_exe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;
    logic [31:0]       instruction;
    logic              stall;
    logic              flush;

    logic              exe_valid;
    logic [DATA_W-1:0] exe_in;
    logic [DATA_W-1:0] exe_a;
    logic [DATA_W-1:0] exe_b;
    logic [11:0]       exe_immed;
    logic [4:0]        exe_opcode;
    logic [3:0]        exe_rd_num;
    logic [2:0]        exe_i_cmd;
    logic              exe_s;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Decode/hazard side: drives the stage inputs, observes the EXE side.
    modport master (
        output id_valid, id_a, id_b, instruction, stall, flush,
        input  exe_valid, exe_in, exe_a, exe_b, exe_immed, exe_opcode,
               exe_rd_num, exe_i_cmd, exe_s, stall_cnt, flush_cnt
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_a, id_b, instruction, stall, flush,
        output exe_valid, exe_in, exe_a, exe_b, exe_immed, exe_opcode,
               exe_rd_num, exe_i_cmd, exe_s, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register. One-cycle latency, priority reset > flush >
// stall > load. An invalid ID slot loads as a bubble so undefined operand or
// instruction bits never reach the EXE control fields. Saturating counters
// track stalled and flushed cycles for performance monitoring.
module id_exe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 1
) (
    input logic   clk,
    input logic   reset,
    id_exe_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              vld_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [11:0]       immed_p1;
    logic [4:0]        opcode_p1;
    logic [3:0]        rd_num_p1;
    logic [2:0]        i_cmd_p1;
    logic              s_p1;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic bubble;
    assign bubble = bus.flush || (!bus.stall && !bus.id_valid);

    // ID -> EXE stage boundary: capture, hold on stall, or insert a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            a_p1      <= '0;
            b_p1      <= '0;
            immed_p1  <= '0;
            opcode_p1 <= '0;
            rd_num_p1 <= '0;
            i_cmd_p1  <= '0;
            s_p1      <= 1'b0;
        end else if (bubble) begin
            vld_p1    <= 1'b0;
            opcode_p1 <= '0;
            rd_num_p1 <= '0;
            i_cmd_p1  <= '0;
            s_p1      <= 1'b0;
            if (CLEAR_DATA != 0) begin
                a_p1     <= '0;
                b_p1     <= '0;
                immed_p1 <= '0;
            end
        end else if (!bus.stall) begin
            vld_p1    <= 1'b1;
            a_p1      <= bus.id_a;
            b_p1      <= bus.id_b;
            immed_p1  <= bus.instruction[11:0];
            opcode_p1 <= bus.instruction[24:20];
            rd_num_p1 <= bus.instruction[15:12];
            i_cmd_p1  <= bus.instruction[27:25];
            s_p1      <= bus.instruction[20];
        end
    end

    // Event counters: flush wins over a simultaneous stall; both saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.flush) begin
            flush_cnt_q <= sat_inc(flush_cnt_q);
        end else if (bus.stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign bus.exe_valid  = vld_p1;
    assign bus.exe_in     = a_p1;
    assign bus.exe_a      = a_p1;
    assign bus.exe_b      = b_p1;
    assign bus.exe_immed  = immed_p1;
    assign bus.exe_opcode = opcode_p1;
    assign bus.exe_rd_num = rd_num_p1;
    assign bus.exe_i_cmd  = i_cmd_p1;
    assign bus.exe_s      = s_p1;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: two instances (CLEAR_DATA=1/CNT_W=16 and
// CLEAR_DATA=0/CNT_W=3) share the same stimulus and are compared against a
// behavioural model every cycle, plus a directed vector table and hand sequences.
module tb_id_exe_stage_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_exe_if #(.DATA_W(32), .CNT_W(16)) bus0 ();
    id_exe_if #(.DATA_W(32), .CNT_W(3))  bus1 ();

    id_exe_stage_reg #(.DATA_W(32), .CNT_W(16), .CLEAR_DATA(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    id_exe_stage_reg #(.DATA_W(32), .CNT_W(3), .CLEAR_DATA(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            n_pass++;
    endtask

    // Behavioural model: index 0 = clearing bubbles, 16-bit counters;
    // index 1 = holding bubbles, 3-bit counters.
    logic        m_vld[2];
    logic [31:0] m_a[2], m_b[2], m_iw[2];
    logic [11:0] m_imm[2];
    int          m_sc[2], m_fc[2];
    int          cmax[2] = '{65535, 7};

    task automatic model_update(input logic r, v, st, fl, input logic [31:0] a, b, ins);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_vld[k] = 0; m_a[k] = 0; m_b[k] = 0; m_iw[k] = 0; m_imm[k] = 0;
                m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (fl || (!st && !v)) begin
                    m_vld[k] = 0; m_iw[k] = 0;
                    if (k == 0) begin m_a[k] = 0; m_b[k] = 0; m_imm[k] = 0; end
                end else if (!st) begin
                    m_vld[k] = 1; m_a[k] = a; m_b[k] = b; m_iw[k] = ins; m_imm[k] = ins[11:0];
                end
                if (fl) m_fc[k] = (m_fc[k] < cmax[k]) ? m_fc[k] + 1 : m_fc[k];
                else if (st) m_sc[k] = (m_sc[k] < cmax[k]) ? m_sc[k] + 1 : m_sc[k];
            end
        end
    endtask

    task automatic check_model(input int k, input logic vld, input logic [31:0] ein, a, b,
                               input logic [11:0] imm, input logic [4:0] op, input logic [3:0] rd,
                               input logic [2:0] icmd, input logic s, input int sc, fc);
        string p;
        p = (k == 0) ? "m0" : "m1";
        check({p, ".valid"},  vld,  m_vld[k]);
        check({p, ".in"},     ein,  m_a[k]);
        check({p, ".a"},      a,    m_a[k]);
        check({p, ".b"},      b,    m_b[k]);
        check({p, ".immed"},  imm,  m_imm[k]);
        check({p, ".opcode"}, op,   m_iw[k][24:20]);
        check({p, ".rd"},     rd,   m_iw[k][15:12]);
        check({p, ".i_cmd"},  icmd, m_iw[k][27:25]);
        check({p, ".s"},      s,    m_iw[k][20]);
        check({p, ".scnt"},   sc,   m_sc[k]);
        check({p, ".fcnt"},   fc,   m_fc[k]);
    endtask

    // Drive both instances, clock once, advance the model, compare after the edge.
    task automatic step(input logic r, v, st, fl, input logic [31:0] a, b, ins);
        reset = r;
        bus0.id_valid = v; bus0.stall = st; bus0.flush = fl;
        bus0.id_a = a; bus0.id_b = b; bus0.instruction = ins;
        bus1.id_valid = v; bus1.stall = st; bus1.flush = fl;
        bus1.id_a = a; bus1.id_b = b; bus1.instruction = ins;
        @(posedge clk);
        model_update(r, v, st, fl, a, b, ins);
        #1;
        check_model(0, bus0.exe_valid, bus0.exe_in, bus0.exe_a, bus0.exe_b, bus0.exe_immed,
                    bus0.exe_opcode, bus0.exe_rd_num, bus0.exe_i_cmd, bus0.exe_s,
                    int'(bus0.stall_cnt), int'(bus0.flush_cnt));
        check_model(1, bus1.exe_valid, bus1.exe_in, bus1.exe_a, bus1.exe_b, bus1.exe_immed,
                    bus1.exe_opcode, bus1.exe_rd_num, bus1.exe_i_cmd, bus1.exe_s,
                    int'(bus1.stall_cnt), int'(bus1.flush_cnt));
    endtask

    typedef struct {
        logic        rst, vld, st, fl;
        logic [31:0] a, b, ins;
        logic        e_vld;
        logic [31:0] e_a, e_b;
        logic [11:0] e_imm;
        logic [4:0]  e_op;
        logic [3:0]  e_rd;
        logic [2:0]  e_icmd;
        logic        e_s;
        int          e_sc, e_fc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1,0,0,0, 0,0,0,                              0,0,0,0,0,0,0,0, 0,0};
        tbl[1]  = '{0,1,0,0, 'h11,'h22,'hE3A01005,               1,'h11,'h22,'h005,'h1A,1,1,0, 0,0};
        tbl[2]  = '{0,1,1,0, 'h33,'h44,'h0B1FA7FF,               1,'h11,'h22,'h005,'h1A,1,1,0, 1,0};
        tbl[3]  = '{0,1,1,0, 'h33,'h44,'h0B1FA7FF,               1,'h11,'h22,'h005,'h1A,1,1,0, 2,0};
        tbl[4]  = '{0,1,1,0, 'h33,'h44,'h0B1FA7FF,               1,'h11,'h22,'h005,'h1A,1,1,0, 3,0};
        tbl[5]  = '{0,1,0,0, 'h33,'h44,'h0B1FA7FF,               1,'h33,'h44,'h7FF,'h11,'hA,5,1, 3,0};
        tbl[6]  = '{0,1,1,1, 'h55,'h66,'hFFFFFFFF,               0,0,0,0,0,0,0,0, 3,1};
        tbl[7]  = '{0,1,0,0, 'h77,'h88,'hE3A01005,               1,'h77,'h88,'h005,'h1A,1,1,0, 3,1};
        tbl[8]  = '{0,0,0,0, 'x,'x,'x,                           0,0,0,0,0,0,0,0, 3,1};
        tbl[9]  = '{0,1,0,0, 'hDEADBEEF,'h12345678,'h0B1FA7FF,   1,'hDEADBEEF,'h12345678,'h7FF,'h11,'hA,5,1, 3,1};
        tbl[10] = '{0,1,1,0, 0,0,0,                              1,'hDEADBEEF,'h12345678,'h7FF,'h11,'hA,5,1, 4,1};
        tbl[11] = '{0,1,1,0, 0,0,0,                              1,'hDEADBEEF,'h12345678,'h7FF,'h11,'hA,5,1, 5,1};
        tbl[12] = '{1,1,1,0, 'hCAFE,'hBEEF,'hE3A01005,           0,0,0,0,0,0,0,0, 0,0};
        tbl[13] = '{0,1,0,0, 1,2,'hE3A01005,                     1,1,2,'h005,'h1A,1,1,0, 0,0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].st, tbl[i].fl, tbl[i].a, tbl[i].b, tbl[i].ins);
            check($sformatf("t%0d.valid", i),  bus0.exe_valid,  tbl[i].e_vld);
            check($sformatf("t%0d.in", i),     bus0.exe_in,     tbl[i].e_a);
            check($sformatf("t%0d.a", i),      bus0.exe_a,      tbl[i].e_a);
            check($sformatf("t%0d.b", i),      bus0.exe_b,      tbl[i].e_b);
            check($sformatf("t%0d.immed", i),  bus0.exe_immed,  tbl[i].e_imm);
            check($sformatf("t%0d.opcode", i), bus0.exe_opcode, tbl[i].e_op);
            check($sformatf("t%0d.rd", i),     bus0.exe_rd_num, tbl[i].e_rd);
            check($sformatf("t%0d.i_cmd", i),  bus0.exe_i_cmd,  tbl[i].e_icmd);
            check($sformatf("t%0d.s", i),      bus0.exe_s,      tbl[i].e_s);
            check($sformatf("t%0d.scnt", i),   bus0.stall_cnt,  tbl[i].e_sc);
            check($sformatf("t%0d.fcnt", i),   bus0.flush_cnt,  tbl[i].e_fc);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom, $urandom, $urandom);
        end

        // Counter saturation: 3-bit counter stops at 7, 16-bit keeps counting.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 0, $urandom, $urandom, $urandom);
            check($sformatf("sat1.scnt%0d", i), bus1.stall_cnt, (i + 1 > 7) ? 7 : i + 1);
            check($sformatf("sat0.scnt%0d", i), bus0.stall_cnt, i + 1);
        end

        // Flush with CLEAR_DATA=0 keeps data but kills valid/control.
        step(0, 1, 0, 0, 'hAB, 'hCD, 'hE3A01005);
        step(0, 1, 0, 1, 'h99, 'h98, 'hFFFFFFFF);
        check("hold1.valid",  bus1.exe_valid,  1'b0);
        check("hold1.a",      bus1.exe_a,      32'hAB);
        check("hold1.b",      bus1.exe_b,      32'hCD);
        check("hold1.immed",  bus1.exe_immed,  12'h005);
        check("hold1.opcode", bus1.exe_opcode, 5'h00);
        check("clear0.a",     bus0.exe_a,      32'h0);
        check("clear0.immed", bus0.exe_immed,  12'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
